uart_tx_framer: RTL

UART_TX_FRAMER -- requirements
Module: uart_tx_framer

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_tx_bit_timer.sv | 27 ++
 rtl/uart_tx_framer.sv | 119 +++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants: TX FSM encoding, parity selects, default width and RX settings.
package uart_pkg;

  localparam int         DATA_W_DEFAULT = 8;
  localparam logic       PAR_EVEN       = 1'b0;
  localparam logic       PAR_ODD        = 1'b1;
  localparam logic [4:0] PRESCALE_MIN   = 5'd2;

  localparam int RX_OVERSAMPLE  = 16;
  localparam int RX_SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  // A bit time shorter than two cycles is not usable, so 0 and 1 map to 2.
  function automatic logic [4:0] clamp_prescale(input logic [4:0] p);
    return (p < PRESCALE_MIN) ? PRESCALE_MIN : p;
  endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit-time counter: counts 0..prescale-1 while run is high and pulses bit_done on the last count.
module uart_tx_bit_timer
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       ARST,
  input  logic       run,
  input  logic [4:0] prescale,
  output logic       bit_done
);

  logic [4:0] cnt_q, cnt_d;

  assign bit_done = run && (cnt_q == (prescale - 5'd1));

  always_comb begin
    cnt_d = cnt_q;
    if (!run || bit_done) cnt_d = '0;
    else                  cnt_d = cnt_q + 5'd1;
  end

  always_ff @(posedge clk or posedge ARST) begin
    if (ARST) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start bit, DATA_W data bits LSB first, optional parity, one stop bit.
// Handshake: data_valid is only looked at in IDLE (busy=0); a request seen while busy is dropped.
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              ARST,
  input  logic [DATA_W-1:0] P_DATA,
  input  logic              data_valid,
  input  logic              PAR_EN,
  input  logic              PAR_TYP,
  input  logic [4:0]        prescale,
  output logic              TX_OUT,
  output logic              busy,
  output tx_state_e         state_dbg_o
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  tx_state_e         state_q;
  logic [DATA_W-1:0] data_q;
  logic [IDX_W-1:0]  bit_idx_q;
  logic [IDX_W-1:0]  next_idx;
  logic              par_en_q;
  logic              par_typ_q;
  logic [4:0]        prescale_q;
  logic              tx_q;
  logic              busy_q;
  logic              bit_done;

  assign next_idx = bit_idx_q + IDX_W'(1);

  uart_tx_bit_timer u_bit_timer (
    .clk      (clk),
    .ARST     (ARST),
    .run      (state_q != IDLE),
    .prescale (prescale_q),
    .bit_done (bit_done)
  );

  always_ff @(posedge clk or posedge ARST) begin
    if (ARST) begin
      state_q    <= IDLE;
      data_q     <= '0;
      bit_idx_q  <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= PAR_EVEN;
      prescale_q <= PRESCALE_MIN;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          if (data_valid) begin
            data_q     <= P_DATA;
            par_en_q   <= PAR_EN;
            par_typ_q  <= PAR_TYP;
            prescale_q <= clamp_prescale(prescale);
            bit_idx_q  <= '0;
            tx_q       <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= START;
          end
        end
        START: begin
          if (bit_done) begin
            tx_q    <= data_q[0];
            state_q <= DATA;
          end
        end
        DATA: begin
          if (bit_done) begin
            if (bit_idx_q == LAST_IDX) begin
              bit_idx_q <= '0;
              if (par_en_q) begin
                tx_q    <= (^data_q) ^ par_typ_q;
                state_q <= PARITY;
              end else begin
                tx_q    <= 1'b1;
                state_q <= STOP;
              end
            end else begin
              bit_idx_q <= next_idx;
              tx_q      <= data_q[next_idx];
            end
          end
        end
        PARITY: begin
          if (bit_done) begin
            tx_q    <= 1'b1;
            state_q <= STOP;
          end
        end
        STOP: begin
          // Leaving STOP drops busy at the same edge, so IDLE always lasts at least one cycle.
          if (bit_done) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign TX_OUT      = tx_q;
  assign busy        = busy_q;
  assign state_dbg_o = state_q;

endmodule
